// File: rtl/crop_window_if.sv
// Control/video/result bundle between the capture path and crop_window_ctrl.
// iSTART and iABORT are single-cycle strobes sampled on iCLK with no ready; a strobe is accepted or dropped.
interface crop_window_if;
    logic        iSTART;
    logic        iABORT;
    logic        iFVAL;
    logic        iDVAL;
    logic [9:0]  iDATA;
    logic        oBUSY;
    logic        oDONE;
    logic        oFAIL;
    logic [15:0] oXSTART;
    logic [15:0] oXEND;
    logic [15:0] oYSTART;
    logic [15:0] oYEND;
    logic [2:0]  oTRIES;

    modport slave (
        input  iSTART, iABORT, iFVAL, iDVAL, iDATA,
        output oBUSY, oDONE, oFAIL, oXSTART, oXEND, oYSTART, oYEND, oTRIES
    );

    modport master (
        output iSTART, iABORT, iFVAL, iDVAL, iDATA,
        input  oBUSY, oDONE, oFAIL, oXSTART, oXEND, oYSTART, oYEND, oTRIES
    );
endinterface

// File: rtl/crop_window_ctrl.sv
// Finds the bounding box of dark pixels inside a search window over up to MAX_TRIES frames
// and publishes it as a locked crop window with a done or fail pulse.
module crop_window_ctrl #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int SX0         = 160,
    parameter int SX1         = 480,
    parameter int SY0         = 120,
    parameter int SY1         = 360,
    parameter int DARK_THRESH = 0,
    parameter int MIN_W       = 8,
    parameter int MIN_H       = 8,
    parameter int MAX_TRIES   = 4
) (
    input  logic         iCLK,
    input  logic         iRST,
    crop_window_if.slave bus,
    output logic [1:0]   oSTATE
);
    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_WAIT_FRAME = 2'd1,
        S_SCAN       = 2'd2,
        S_EVAL       = 2'd3
    } state_t;

    localparam logic [15:0] L_H_LAST = 16'(H_ACTIVE - 1);
    localparam logic [15:0] L_V      = 16'(V_ACTIVE);
    localparam logic [15:0] L_SX0    = 16'(SX0);
    localparam logic [15:0] L_SX1    = 16'(SX1);
    localparam logic [15:0] L_SY0    = 16'(SY0);
    localparam logic [15:0] L_SY1    = 16'(SY1);
    localparam logic [9:0]  L_DARK   = 10'(DARK_THRESH);
    localparam logic [15:0] L_MIN_W  = 16'(MIN_W);
    localparam logic [15:0] L_MIN_H  = 16'(MIN_H);
    localparam logic [2:0]  L_MAX    = 3'(MAX_TRIES);

    state_t      r_state, w_state_nxt;
    logic        r_fval, r_found, r_busy, r_done, r_fail;
    logic [15:0] r_x, r_y, r_xmin, r_xmax, r_ymin, r_ymax;
    logic [15:0] r_xs, r_xe, r_ys, r_ye;
    logic [2:0]  r_tries;

    logic        w_rise, w_fall, w_ok;
    logic        w_accept, w_init, w_count, w_pass, w_fail, w_stop;
    logic [15:0] w_width, w_height;
    logic [15:0] w_px, w_py, w_xmin_b, w_xmax_b, w_ymin_b, w_ymax_b;
    logic        w_found_b, w_beat, w_dark, w_in_win, w_hit, w_x_wrap;

    assign w_rise   = bus.iFVAL && !r_fval;
    assign w_fall   = !bus.iFVAL && r_fval;
    assign w_width  = r_xmax - r_xmin + 16'd1;
    assign w_height = r_ymax - r_ymin + 16'd1;
    assign w_ok     = r_found && (w_width >= L_MIN_W) && (w_height >= L_MIN_H);

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_init      = 1'b0;
        w_count     = 1'b0;
        w_pass      = 1'b0;
        w_fail      = 1'b0;
        w_stop      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.iSTART && !bus.iABORT) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_WAIT_FRAME;
                end
            end
            S_WAIT_FRAME: begin
                if (bus.iABORT) begin
                    w_stop      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (w_rise) begin
                    // The beat coincident with the frame rise is pixel (0,0).
                    w_init      = 1'b1;
                    w_count     = bus.iDVAL;
                    w_state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                if (bus.iABORT) begin
                    w_stop      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (w_fall) begin
                    w_state_nxt = S_EVAL;
                end else begin
                    w_count = bus.iDVAL;
                end
            end
            S_EVAL: begin
                if (bus.iABORT) begin
                    w_stop      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (w_ok) begin
                    w_pass      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_tries < L_MAX) begin
                    w_state_nxt = S_WAIT_FRAME;
                end else begin
                    w_fail      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // On the frame-start cycle the scan registers are seen as already cleared.
    assign w_px      = w_init ? 16'd0     : r_x;
    assign w_py      = w_init ? 16'd0     : r_y;
    assign w_xmin_b  = w_init ? 16'hFFFF  : r_xmin;
    assign w_ymin_b  = w_init ? 16'hFFFF  : r_ymin;
    assign w_xmax_b  = w_init ? 16'd0     : r_xmax;
    assign w_ymax_b  = w_init ? 16'd0     : r_ymax;
    assign w_found_b = w_init ? 1'b0      : r_found;
    assign w_beat    = w_count && (w_py != L_V);
    assign w_dark    = bus.iDATA <= L_DARK;
    assign w_in_win  = (w_px >= L_SX0) && (w_px <= L_SX1) && (w_py >= L_SY0) && (w_py <= L_SY1);
    assign w_hit     = w_beat && w_dark && w_in_win;
    assign w_x_wrap  = (w_px == L_H_LAST);

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_fval  <= 1'b0;
            r_x     <= 16'd0;
            r_y     <= 16'd0;
            r_found <= 1'b0;
            r_xmin  <= 16'hFFFF;
            r_ymin  <= 16'hFFFF;
            r_xmax  <= 16'd0;
            r_ymax  <= 16'd0;
        end else begin
            r_fval <= bus.iFVAL;
            if (w_init || w_beat) begin
                r_x     <= w_beat ? (w_x_wrap ? 16'd0 : w_px + 16'd1) : w_px;
                r_y     <= (w_beat && w_x_wrap) ? w_py + 16'd1 : w_py;
                r_found <= w_found_b || w_hit;
                r_xmin  <= (w_hit && (w_px < w_xmin_b)) ? w_px : w_xmin_b;
                r_xmax  <= (w_hit && (w_px > w_xmax_b)) ? w_px : w_xmax_b;
                r_ymin  <= (w_hit && (w_py < w_ymin_b)) ? w_py : w_ymin_b;
                r_ymax  <= (w_hit && (w_py > w_ymax_b)) ? w_py : w_ymax_b;
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_fail  <= 1'b0;
            r_tries <= 3'd0;
            r_xs    <= 16'd0;
            r_xe    <= 16'd0;
            r_ys    <= 16'd0;
            r_ye    <= 16'd0;
        end else begin
            r_done <= w_pass;
            r_fail <= w_fail;
            if (w_accept)                      r_busy <= 1'b1;
            else if (w_pass || w_fail || w_stop) r_busy <= 1'b0;
            if (w_accept)    r_tries <= 3'd0;
            else if (w_init) r_tries <= r_tries + 3'd1;
            if (w_pass) begin
                r_xs <= r_xmin;
                r_xe <= r_xmax;
                r_ys <= r_ymin;
                r_ye <= r_ymax;
            end
        end
    end

    assign bus.oBUSY   = r_busy;
    assign bus.oDONE   = r_done;
    assign bus.oFAIL   = r_fail;
    assign bus.oXSTART = r_xs;
    assign bus.oXEND   = r_xe;
    assign bus.oYSTART = r_ys;
    assign bus.oYEND   = r_ye;
    assign bus.oTRIES  = r_tries;
    assign oSTATE      = r_state;
endmodule

// File: tb/tb_crop_window_ctrl.sv
// Bench for crop_window_ctrl on a reduced 40x32 frame: table of runs plus hand-written
// mid-frame start, retry, abort and reset sequences; results checked through a queue.
module tb_crop_window_ctrl;
    localparam int H  = 40;
    localparam int V  = 32;
    localparam int RW = 69;

    typedef struct {
        int             bx0, bx1, by0, by1;
        bit             ocol;
        int             nfr;
        logic [RW-1:0]  exp;
    } run_t;

    logic iCLK = 1'b0;
    logic iRST = 1'b0;
    logic [1:0] state_dbg;
    crop_window_if bus ();

    crop_window_ctrl #(
        .H_ACTIVE(H), .V_ACTIVE(V), .SX0(10), .SX1(30), .SY0(8), .SY1(24),
        .DARK_THRESH(0), .MIN_W(8), .MIN_H(8), .MAX_TRIES(4)
    ) dut (
        .iCLK   (iCLK),
        .iRST   (iRST),
        .bus    (bus),
        .oSTATE (state_dbg)
    );

    always #5 iCLK = ~iCLK;

    int cyc = 0;
    always @(posedge iCLK) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;
    logic [RW-1:0] exp_q[$];
    int            cyc_q[$];

    function automatic void chk(string nm, logic [RW-1:0] act, logic [RW-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", nm, act, req);
        end
    endfunction

    function automatic logic [RW-1:0] res(logic [1:0] kind, int xs, int xe, int ys, int ye, int tr);
        return {kind, 16'(xs), 16'(xe), 16'(ys), 16'(ye), 3'(tr)};
    endfunction

    // Pulse monitor: every done/fail pulse must match the head of the expected queue.
    always @(negedge iCLK) begin
        if (iRST && (bus.oDONE || bus.oFAIL)) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_pulse: actual done=%0b fail=%0b required none", bus.oDONE, bus.oFAIL);
            end else begin
                chk("result", {bus.oFAIL, bus.oDONE, bus.oXSTART, bus.oXEND, bus.oYSTART, bus.oYEND, bus.oTRIES},
                    exp_q.pop_front());
                chk("pulse_cycle", RW'(cyc), RW'(cyc_q.pop_front()));
                chk("busy_at_pulse", RW'(bus.oBUSY), RW'(0));
            end
        end
    end

    task automatic step();
        @(posedge iCLK);
        #1;
    endtask

    task automatic pulse_start();
        bus.iSTART = 1'b1;
        step();
        bus.iSTART = 1'b0;
    endtask

    task automatic send_frame(input int bx0, input int bx1, input int by0, input int by1, input bit ocol,
                              input int start_at, input int abort_at, input bit do_push,
                              input logic [RW-1:0] expv);
        int  idx = 0;
        bit  dark;
        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < H; x++) begin
                dark = (bx0 >= 0 && x >= bx0 && x <= bx1 && y >= by0 && y <= by1) || (ocol && x == 5);
                bus.iFVAL  = 1'b1;
                bus.iDVAL  = 1'b1;
                bus.iDATA  = dark ? 10'd0 : 10'($urandom_range(1, 1023));
                bus.iSTART = (idx == start_at);
                bus.iABORT = (idx == abort_at);
                if (idx == abort_at) chk("busy_pre_abort", RW'(bus.oBUSY), RW'(1));
                step();
                if (idx == abort_at) begin
                    chk("busy_after_abort", RW'(bus.oBUSY), RW'(0));
                    chk("state_after_abort", RW'(state_dbg), RW'(0));
                end
                idx++;
            end
            bus.iDVAL  = 1'b0;
            bus.iSTART = 1'b0;
            bus.iABORT = 1'b0;
            bus.iDATA  = 10'h3FF;
            step();
            step();
        end
        bus.iFVAL = 1'b0;
        bus.iDVAL = 1'b0;
        if (do_push) begin
            exp_q.push_back(expv);
            cyc_q.push_back(cyc + 2);
        end
        for (int i = 0; i < 6; i++) step();
        if (do_push) chk("drain", RW'(exp_q.size()), RW'(0));
    endtask

    run_t runs[8];

    initial begin
        runs[0] = '{12, 19, 10, 17, 1'b0, 1, res(2'b01, 12, 19, 10, 17, 1)};
        runs[1] = '{10, 30,  8, 24, 1'b0, 1, res(2'b01, 10, 30,  8, 24, 1)};
        runs[2] = '{ 5, 35,  4, 28, 1'b0, 1, res(2'b01, 10, 30,  8, 24, 1)};
        runs[3] = '{12, 18, 10, 17, 1'b0, 4, res(2'b10, 10, 30,  8, 24, 4)};
        runs[4] = '{-1, -1, -1, -1, 1'b1, 4, res(2'b10, 10, 30,  8, 24, 4)};
        runs[5] = '{20, 29, 15, 24, 1'b1, 1, res(2'b01, 20, 29, 15, 24, 1)};
        runs[6] = '{10, 17, 17, 24, 1'b0, 1, res(2'b01, 10, 17, 17, 24, 1)};
        runs[7] = '{20, 27, 10, 16, 1'b0, 4, res(2'b10, 10, 17, 17, 24, 4)};

        bus.iSTART = 1'b0;
        bus.iABORT = 1'b0;
        bus.iFVAL  = 1'b0;
        bus.iDVAL  = 1'b0;
        bus.iDATA  = 10'h3FF;
        iRST = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("reset_outputs", {bus.oFAIL, bus.oDONE, bus.oXSTART, bus.oXEND, bus.oYSTART, bus.oYEND, bus.oTRIES}, '0);
        chk("reset_busy_state", RW'({bus.oBUSY, state_dbg}), RW'(0));
        iRST = 1'b1;
        step();

        for (int r = 0; r < 8; r++) begin
            pulse_start();
            chk("busy_after_start", RW'(bus.oBUSY), RW'(1));
            chk("tries_after_start", RW'(bus.oTRIES), RW'(0));
            for (int f = 0; f < runs[r].nfr; f++)
                send_frame(runs[r].bx0, runs[r].bx1, runs[r].by0, runs[r].by1, runs[r].ocol,
                           -1, -1, (f == runs[r].nfr - 1), runs[r].exp);
        end

        // Start arrives mid-frame: that frame is skipped, the next one decides.
        send_frame(12, 19, 10, 17, 1'b0, 100, -1, 1'b0, '0);
        chk("busy_mid_frame_start", RW'(bus.oBUSY), RW'(1));
        send_frame(12, 19, 10, 17, 1'b0, -1, -1, 1'b1, res(2'b01, 12, 19, 10, 17, 1));

        // Too-small box first, valid box on the retry.
        pulse_start();
        send_frame(12, 15, 10, 13, 1'b0, -1, -1, 1'b0, '0);
        chk("busy_during_retry", RW'(bus.oBUSY), RW'(1));
        send_frame(20, 29, 12, 21, 1'b0, -1, -1, 1'b1, res(2'b01, 20, 29, 12, 21, 2));

        // Abort during the second scan, then start+abort together is dropped.
        pulse_start();
        send_frame(12, 15, 10, 13, 1'b0, -1, -1, 1'b0, '0);
        send_frame(20, 29, 12, 21, 1'b0, -1, 200, 1'b0, '0);
        chk("held_after_abort", RW'({bus.oXSTART, bus.oXEND, bus.oYSTART, bus.oYEND, bus.oTRIES}),
            RW'({16'd20, 16'd29, 16'd12, 16'd21, 3'd2}));
        bus.iSTART = 1'b1;
        bus.iABORT = 1'b1;
        step();
        bus.iSTART = 1'b0;
        bus.iABORT = 1'b0;
        chk("start_abort_busy", RW'(bus.oBUSY), RW'(0));
        step();
        chk("start_abort_state", RW'(state_dbg), RW'(0));

        // Reset in the middle of a scan.
        pulse_start();
        for (int i = 0; i < 100; i++) begin
            bus.iFVAL = 1'b1;
            bus.iDVAL = 1'b1;
            bus.iDATA = 10'($urandom_range(0, 1023));
            step();
        end
        #2 iRST = 1'b0;
        #1;
        chk("midreset_outputs", {bus.oFAIL, bus.oDONE, bus.oXSTART, bus.oXEND, bus.oYSTART, bus.oYEND, bus.oTRIES}, '0);
        chk("midreset_busy_state", RW'({bus.oBUSY, state_dbg}), RW'(0));
        bus.iFVAL = 1'b0;
        bus.iDVAL = 1'b0;
        for (int i = 0; i < 3; i++) step();
        iRST = 1'b1;
        for (int i = 0; i < 3; i++) step();
        pulse_start();
        send_frame(12, 19, 10, 17, 1'b0, -1, -1, 1'b1, res(2'b01, 12, 19, 10, 17, 1));

        for (int i = 0; i < 5; i++) step();
        chk("queue_empty_at_end", RW'(exp_q.size()), RW'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
